simd_elastic_buf: RTL
=====================

Name: simd_elastic_buf

Overview:
- Parametrised successor to the flat 32-bit pass-through buffer. Registered elastic FIFO buffer carrying LANES x LANE_W SIMD data with a per-lane valid mask.
- Uses a valid/ready handshake on both sides, a flush, and an occupancy count.
- Sits between DLX pipeline stages (e.g. ID->EX operand path) to decouple stalls without combinational ready paths.

Parameters:
- LANES, 4, number of SIMD lanes
- LANE_W, 8, bits per lane; data width W = LANES*LANE_W (default 32)
- DEPTH, 4, number of entries; power of two, >= 2
- CNT_W, $clog2(DEPTH+1), width of COUNT

Ports:
- CLK  input  1  clock, all state on rising edge
- RESET_N  input  1  synchronous active-low reset
- I_VALID  input  1  producer has a word
- I_READY  output  1  buffer can accept (registered, = not full)
- I_DATA  input  W  SIMD word
- I_MASK  input  LANES  per-lane enable for I_DATA
- O_VALID  output  1  head entry present (registered)
- O_READY  input  1  consumer takes head this cycle
- O_DATA  output  W  head word, disabled lanes forced to 0
- O_MASK  output  LANES  head lane mask
- FLUSH  input  1  discard all entries
- COUNT  output  CNT_W  current occupancy 0..DEPTH

Behaviour:
- Reset (RESET_N=0 at a clock edge): wr_ptr=rd_ptr=0, COUNT=0, O_VALID=0, I_READY=1, O_DATA=0, O_MASK=0. Storage contents are don't-care.
- Reset has priority over FLUSH, push and pop. Reset mid-transfer drops all data.
- push = I_VALID & I_READY; pop = O_VALID & O_READY.
- Push writes {I_MASK, I_DATA} at wr_ptr. wr_ptr advances modulo DEPTH and wraps naturally because DEPTH is a power of two.
- Pop advances rd_ptr modulo DEPTH.
- O_DATA/O_MASK are driven from the entry at rd_ptr. Lane k of O_DATA = mask[k] ? data[k*LANE_W +: LANE_W] : 0.
- When O_VALID=0, O_DATA and O_MASK are 0.
- Latency: a word pushed at edge n appears with O_VALID=1 after edge n. No same-cycle fall-through from input to output.
- COUNT next = COUNT + push - pop. Push and pop in the same cycle leave COUNT unchanged and are legal at any occupancy 1..DEPTH-1.
- Full (COUNT=DEPTH): I_READY=0, so push cannot happen. A pop in that cycle makes I_READY=1 on the next cycle only; there is no same-cycle ready bypass.
- Empty (COUNT=0): O_VALID=0, so pop cannot happen. O_READY is ignored.
- I_READY = (COUNT != DEPTH); O_VALID = (COUNT != 0). Both are derived from registered COUNT; neither depends combinationally on I_VALID or O_READY.
- FLUSH=1 at an edge: pointers and COUNT go to 0 and O_VALID=0 next cycle. A push or pop offered in the same cycle is discarded. Storage is not cleared.
- I_MASK=0 with I_VALID=1 is a legal push; the entry occupies a slot and outputs all-zero data with O_MASK=0.
- Illegal conditions are assertion-only in simulation, not handled in RTL:
  - I_VALID dropping before acceptance (the producer must hold I_VALID/I_DATA/I_MASK stable until I_READY).
  - DEPTH not a power of two.
- No X propagation: unused lanes are zeroed, never passed through.

Decomposition:
- Shared package/include (dlx_simd_defs):
  - LANES and LANE_W defaults
  - W derivation
  - lane-select helper constants
- One sub-module: simd_lane_mask, combinational. Inputs: W-bit data and LANES mask; output: masked data. It is reused by other SIMD stages.
- Storage array, pointers and count stay in simd_elastic_buf.

Test Plan:
- Reset then idle:
  - hold RESET_N=0 for 2 cycles with I_VALID=1 -> COUNT=0, O_VALID=0, I_READY=1, O_DATA=0 throughout.
  - release RESET_N -> first push accepted next edge.
- Fill to full:
  - push 0x11111111, 0x22222222, 0x33333333, 0x44444444 with mask 4'hF, O_READY=0 -> COUNT=4 and I_READY=0.
  - fifth word 0x55555555 held -> not accepted.
  - then O_READY=1 -> outputs in order 0x11..,0x22..,0x33..,0x44.., followed by 0x55555555 once I_READY returns.
- Simultaneous push/pop at COUNT=2 for 8 cycles, incrementing data -> COUNT stays 2 and the output order is preserved across pointer wrap (>DEPTH total transfers).
- Lane masking: push 0xAABBCCDD with mask 4'b0101 -> O_DATA=0x00BB00DD, O_MASK=4'b0101.
- Flush:
  - at COUNT=3, assert FLUSH with I_VALID=1 and O_READY=1 in the same cycle -> next cycle COUNT=0 and O_VALID=0; the offered word is absent from later output.
  - then push 0x12345678 -> it is the next word out.
- Reset mid-stream: at COUNT=3, RESET_N=0 for 1 cycle -> COUNT=0, O_VALID=0; no pre-reset words appear afterwards.

Source files
------------

// File: rtl/dlx_simd_defs.sv
// Shared SIMD definitions for the DLX datapath: lane geometry defaults,
// word width derivation and lane-select helpers.
package dlx_simd_defs;

    localparam int LANES_DEF  = 4;
    localparam int LANE_W_DEF = 8;
    localparam int W_DEF      = LANES_DEF * LANE_W_DEF;

    // Full SIMD word width for a given lane geometry.
    function automatic int simd_w(input int lanes, input int lane_w);
        return lanes * lane_w;
    endfunction

    // Bit position of the least significant bit of lane k.
    function automatic int lane_lsb(input int k, input int lane_w);
        return k * lane_w;
    endfunction

endpackage

// File: rtl/simd_lane_mask.sv
// Combinational lane masker: lanes whose mask bit is clear are forced to
// zero so that stale or undefined lane contents never leave a stage.
module simd_lane_mask
    import dlx_simd_defs::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int LANE_W = LANE_W_DEF
) (
    input  logic [LANES*LANE_W-1:0] data,
    input  logic [LANES-1:0]        mask,
    output logic [LANES*LANE_W-1:0] masked
);

    // Copy enabled lanes, everything else stays zero.
    always_comb begin
        masked = '0;
        for (int k = 0; k < LANES; k++) begin
            if (mask[k]) begin
                masked[lane_lsb(k, LANE_W) +: LANE_W] = data[lane_lsb(k, LANE_W) +: LANE_W];
            end
        end
    end

endmodule

// File: rtl/simd_elastic_buf.sv
// Registered elastic FIFO for LANES x LANE_W SIMD words with a per-lane
// valid mask. Both handshake readies/valids come from the registered
// occupancy, so no combinational path crosses the buffer.
module simd_elastic_buf
    import dlx_simd_defs::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int LANE_W = LANE_W_DEF,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic                    I_VALID,
    output logic                    I_READY,
    input  logic [LANES*LANE_W-1:0] I_DATA,
    input  logic [LANES-1:0]        I_MASK,
    output logic                    O_VALID,
    input  logic                    O_READY,
    output logic [LANES*LANE_W-1:0] O_DATA,
    output logic [LANES-1:0]        O_MASK,
    input  logic                    FLUSH,
    output logic [CNT_W-1:0]        COUNT
);

    localparam int W     = simd_w(LANES, LANE_W);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     data_mem [DEPTH];
    logic [LANES-1:0] mask_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic [LANES-1:0] head_mask;

    assign I_READY = (count != CNT_W'(DEPTH));
    assign O_VALID = (count != '0);
    assign COUNT   = count;
    assign push    = I_VALID & I_READY;
    assign pop     = O_VALID & O_READY;

    // Pointer and occupancy control; reset beats flush, flush beats traffic.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (FLUSH) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is data only; a write during reset/flush lands in a slot that
    // the cleared pointers no longer consider valid.
    always_ff @(posedge CLK) begin
        if (push) begin
            data_mem[wr_ptr] <= I_DATA;
            mask_mem[wr_ptr] <= I_MASK;
        end
    end

    // An empty buffer presents an all-zero mask, which zeroes every lane.
    always_comb begin
        head_mask = '0;
        if (O_VALID) head_mask = mask_mem[rd_ptr];
    end

    assign O_MASK = head_mask;

    simd_lane_mask #(
        .LANES  (LANES),
        .LANE_W (LANE_W)
    ) u_lane_mask (
        .data   (data_mem[rd_ptr]),
        .mask   (head_mask),
        .masked (O_DATA)
    );

    // The producer must hold its word stable while stalled.
    a_hold_while_stalled: assert property (
        @(posedge CLK) disable iff (!RESET_N || FLUSH)
        (I_VALID && !I_READY) |=> (I_VALID && $stable(I_DATA) && $stable(I_MASK))
    ) else $error("simd_elastic_buf: producer changed word before acceptance");

    // Pointer wrap relies on a power-of-two depth.
    a_depth_pow2: assert property (
        @(posedge CLK) (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0)
    ) else $error("simd_elastic_buf: DEPTH must be a power of two >= 2");

endmodule
